lcd_ctrl_param: RTL and testbench

Parametrised second-generation LCD display controller. It loads an N×N grayscale image (N = 2·WIN) over a byte-serial port and holds it in an internal register array. Each display command produces a WIN×WIN output window, either a 2:1 subsampled "fit" view or a movable 1:1 "zoom" view. Adds generic image/window/data sizes and persistent horizontal/vertical mirror modes. Sits between the host command source and the panel driver.

---
 rtl/lcd_ctrl_pkg.sv | 35 +++
 rtl/lcd_img_ram.sv | 28 ++
 rtl/lcd_ctrl_param.sv | 163 ++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared types for the parametrised LCD controller: command codes, FSM states,
// view modes and a width helper for address/coordinate counters.
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_REFRESH  = 4'd0,
        CMD_LOAD     = 4'd1,
        CMD_ZOOM_IN  = 4'd2,
        CMD_ZOOM_FIT = 4'd3,
        CMD_SHIFT_R  = 4'd4,
        CMD_SHIFT_L  = 4'd5,
        CMD_SHIFT_U  = 4'd6,
        CMD_SHIFT_D  = 4'd7,
        CMD_MIRROR_X = 4'd8,
        CMD_MIRROR_Y = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OUT,
        ST_NOP
    } state_e;

    typedef enum logic {
        MODE_FIT,
        MODE_ZOOM
    } mode_e;

    // Bits needed to index 0..count-1, never less than one.
    function automatic int width_of(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/lcd_img_ram.sv
// Image store: DEPTH x DW register array, synchronous write, combinational read.
// No reset on the array; contents are only meaningful after a full load.
module lcd_img_ram
    import lcd_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    localparam int AW   = width_of(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD controller: loads an N x N image (N = 2*WIN) and streams WIN x WIN fit/zoom windows
// with optional mirroring. Commands are dropped while busy; outputs are registered.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int DW  = 8,
    parameter int WIN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N     = 2 * WIN;
    localparam int DEPTH = N * N;
    localparam int AW    = width_of(DEPTH);
    localparam int XW    = width_of(N);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] OUT_WORDS = AW'(WIN * WIN);
    localparam logic [AW-1:0] CNT_ONE   = AW'(1);
    localparam logic [XW-1:0] CRD_ONE   = XW'(1);
    localparam logic [XW-1:0] ORG_INIT  = XW'(WIN / 2);
    localparam logic [XW-1:0] ORG_MAX   = XW'(N - WIN);
    localparam logic [XW-1:0] WIN_LAST  = XW'(WIN - 1);

    state_e        state, state_nxt;
    mode_e         mode;
    logic [XW-1:0] org_x, org_y;
    logic          mir_x, mir_y;
    logic [AW-1:0] cnt;
    logic [XW-1:0] out_r, out_c;

    logic          cmd_legal;
    logic          load_done;
    logic          out_done;
    logic [XW-1:0] rm, cm, row, col;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_pix;

    assign cmd_legal = (cmd <= 4'd9);
    assign load_done = (state == ST_LOAD) && (cnt == LAST_ADDR);
    assign out_done  = (state == ST_OUT) && (cnt == OUT_WORDS);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == CMD_LOAD) begin
                        state_nxt = ST_LOAD;
                    end else if (cmd_legal) begin
                        state_nxt = ST_OUT;
                    end else begin
                        state_nxt = ST_NOP;
                    end
                end
            end
            ST_LOAD: if (load_done) state_nxt = ST_OUT;
            ST_OUT:  if (out_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mirroring flips the window coordinate before the view mapping is applied.
    assign rm  = mir_y ? (WIN_LAST - out_r) : out_r;
    assign cm  = mir_x ? (WIN_LAST - out_c) : out_c;
    assign row = (mode == MODE_FIT) ? {rm[XW-2:0], 1'b1} : (org_y + rm);
    assign col = (mode == MODE_FIT) ? {cm[XW-2:0], 1'b1} : (org_x + cm);
    assign rd_addr = AW'(row) * AW'(N) + AW'(col);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode         <= MODE_FIT;
            org_x        <= ORG_INIT;
            org_y        <= ORG_INIT;
            mir_x        <= 1'b0;
            mir_y        <= 1'b0;
            cnt          <= '0;
            out_r        <= '0;
            out_c        <= '0;
            dataout      <= '0;
            output_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt          <= '0;
                    out_r        <= '0;
                    out_c        <= '0;
                    output_valid <= 1'b0;
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_ZOOM_IN:  mode <= MODE_ZOOM;
                            CMD_ZOOM_FIT: mode <= MODE_FIT;
                            CMD_SHIFT_R:  if (mode == MODE_ZOOM && org_x < ORG_MAX) org_x <= org_x + CRD_ONE;
                            CMD_SHIFT_L:  if (mode == MODE_ZOOM && org_x != '0)     org_x <= org_x - CRD_ONE;
                            CMD_SHIFT_U:  if (mode == MODE_ZOOM && org_y != '0)     org_y <= org_y - CRD_ONE;
                            CMD_SHIFT_D:  if (mode == MODE_ZOOM && org_y < ORG_MAX) org_y <= org_y + CRD_ONE;
                            CMD_MIRROR_X: mir_x <= ~mir_x;
                            CMD_MIRROR_Y: mir_y <= ~mir_y;
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (load_done) begin
                        cnt   <= '0;
                        mode  <= MODE_FIT;
                        org_x <= ORG_INIT;
                        org_y <= ORG_INIT;
                        mir_x <= 1'b0;
                        mir_y <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_OUT: begin
                    if (out_done) begin
                        output_valid <= 1'b0;
                    end else begin
                        output_valid <= 1'b1;
                        dataout      <= rd_pix;
                        cnt          <= cnt + CNT_ONE;
                        if (out_c == WIN_LAST) begin
                            out_c <= '0;
                            out_r <= out_r + CRD_ONE;
                        end else begin
                            out_c <= out_c + CRD_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    lcd_img_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_img_ram (
        .clk   (clk),
        .we    (state == ST_LOAD),
        .waddr (cnt),
        .wdata (datain),
        .raddr (rd_addr),
        .rdata (rd_pix)
    );

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param (WIN=4, N=8, image pixel = address).
module tb_lcd_ctrl_param;
    import lcd_ctrl_pkg::*;

    localparam int DW  = 8;
    localparam int WIN = 4;
    localparam int N   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    lcd_ctrl_param #(.DW(DW), .WIN(WIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_out = 0;
    int busy_edges = 0;
    int exp_q[$];

    int m_zoom, m_x, m_y, m_mx, m_my;
    int lit[16];
    bit lit_on = 1'b0;

    localparam int FIT_L[16]  = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};
    localparam int ZOOM_L[16] = '{18, 19, 20, 21, 26, 27, 28, 29, 34, 35, 36, 37, 42, 43, 44, 45};

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (busy) busy_edges++;
        if (output_valid) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_output", int'(dataout), -1);
            else check("pixel", int'(dataout), exp_q.pop_front());
        end
    end

    function automatic void model_reset();
        m_zoom = 0; m_x = WIN / 2; m_y = WIN / 2; m_mx = 0; m_my = 0;
    endfunction

    function automatic void push_view();
        int rr, cc, row, col;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                rr = m_my ? WIN - 1 - r : r;
                cc = m_mx ? WIN - 1 - c : c;
                row = m_zoom ? m_y + rr : 2 * rr + 1;
                col = m_zoom ? m_x + cc : 2 * cc + 1;
                exp_q.push_back(row * N + col);
            end
        end
    endfunction

    // Updates the reference model for a command and queues its expected window.
    function automatic void model_cmd(input int c);
        case (c)
            1: model_reset();
            2: m_zoom = 1;
            3: m_zoom = 0;
            4: if (m_zoom && m_x < N - WIN) m_x++;
            5: if (m_zoom && m_x > 0) m_x--;
            6: if (m_zoom && m_y > 0) m_y--;
            7: if (m_zoom && m_y < N - WIN) m_y++;
            8: m_mx = !m_mx;
            9: m_my = !m_my;
            default: ;
        endcase
        if (c <= 9) begin
            if (lit_on) begin
                for (int i = 0; i < 16; i++) exp_q.push_back(lit[i]);
            end else begin
                push_view();
            end
        end
        lit_on = 1'b0;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("busy_timeout", 1, 0);
    endtask

    task automatic run_cmd(input int c, input int exp_busy, input int exp_words,
                           input string tag, input bit poke);
        int b0, o0;
        wait_idle();
        model_cmd(c);
        b0 = busy_edges;
        o0 = n_out;
        cmd = 4'(c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = 4'd0;
        if (c == 1) begin
            for (int i = 0; i < N * N; i++) begin
                datain = DW'(i);
                @(negedge clk);
            end
        end
        if (poke) begin
            repeat (3) @(negedge clk);
            cmd = 4'd3;
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd = 4'd0;
        end
        wait_idle();
        check({tag, "_busy_cycles"}, busy_edges - b0, exp_busy);
        check({tag, "_words"}, n_out - o0, exp_words);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int o0, t;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd = 4'd0;
        datain = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(output_valid), 0);
        check("reset_dataout", int'(dataout), 0);
        reset = 1'b0;
        model_reset();

        lit = FIT_L;  lit_on = 1'b1; run_cmd(1, 81, 16, "load", 1'b0);
        lit = ZOOM_L; lit_on = 1'b1; run_cmd(2, 17, 16, "zoom_in", 1'b0);
        for (int i = 0; i < 3; i++) run_cmd(4, 17, 16, "shift_r", 1'b0);
        run_cmd(8, 17, 16, "mirror_x", 1'b0);
        run_cmd(9, 17, 16, "mirror_y", 1'b0);
        run_cmd(0, 17, 16, "refresh_mirrored", 1'b0);
        lit = FIT_L;  lit_on = 1'b1; run_cmd(1, 81, 16, "reload", 1'b0);
        run_cmd(4, 17, 16, "shift_r_fit", 1'b0);
        lit = ZOOM_L; lit_on = 1'b1; run_cmd(2, 17, 16, "zoom_after_fit_shift", 1'b0);

        run_cmd(12, 1, 0, "illegal", 1'b0);
        run_cmd(0, 17, 16, "refresh_poked", 1'b1);
        run_cmd(0, 17, 16, "refresh_after_poke", 1'b0);
        for (int i = 0; i < 3; i++) run_cmd(6, 17, 16, "shift_u", 1'b0);
        run_cmd(5, 17, 16, "shift_l", 1'b0);
        run_cmd(7, 17, 16, "shift_d", 1'b0);
        run_cmd(9, 17, 16, "mirror_y_zoom", 1'b0);
        run_cmd(3, 17, 16, "zoom_fit_mirrored", 1'b0);

        // Abort a zoom readout at its fifth word.
        wait_idle();
        model_cmd(2);
        o0 = n_out;
        cmd = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = 4'd0;
        t = 0;
        while (n_out < o0 + 5 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("words_before_reset", n_out - o0, 5);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrun_reset_valid", int'(output_valid), 0);
        check("midrun_reset_busy", int'(busy), 0);
        reset = 1'b0;
        model_reset();
        lit = FIT_L;  lit_on = 1'b1; run_cmd(1, 81, 16, "load_after_reset", 1'b0);
        lit = ZOOM_L; lit_on = 1'b1; run_cmd(2, 17, 16, "zoom_after_reset", 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
